pwm_capture: RTL and testbench
==============================

# pwm_capture

Receive-side counterpart of the team's PWM generator. Measures an incoming PWM waveform's high time and period in `clk` cycles, then computes a normalised duty word of the same width the generator takes as its `duty` input. Used for loop-back checking of the generator, and for decoding PWM from external sources. `pwm_in` is asynchronous to `clk` and is synchronised internally.

## Interface

**Parameters**
- `WIDTH`, default 8: width of the normalised duty output.
- `CNT_WIDTH`, default 16: width of the high-time and period counters. The stuck timeout is 2^CNT_WIDTH−1 cycles.

**Ports**
- `clk`, input, 1: single clock; every register is on its rising edge.
- `reset`, input, 1: asynchronous, active-high reset.
- `pwm_in`, input, 1: PWM waveform under measurement; asynchronous.
- `duty`, output, WIDTH: floor(high_cnt·2^WIDTH / period_cnt) from the last completed measurement.
- `high_cnt`, output, CNT_WIDTH: cycles high in the last completed period.
- `period_cnt`, output, CNT_WIDTH: cycles between the last two rising edges.
- `valid`, output, 1: one-cycle pulse when `duty`/`high_cnt`/`period_cnt` update.
- `stuck`, output, 1: level; no rising edge seen for the timeout.
- `stuck_level`, output, 1: synchronised `pwm_in` level when `stuck` asserted.

## Operation

**Front end**
- 2-flop synchroniser, then one history flop. All three reset to 1, so an input that is already high at reset release creates no false rising edge.
- `rise` = sync & ~hist; `fall` = ~sync & hist.

**Measurement FSM**
- IDLE: counters held at 0. On `rise`: clear counters, go to MEASURE.
- MEASURE:
  - `cnt` increments every cycle; `hcnt` increments while sync = 1.
  - On `rise`:
    - latch `cnt+1` as the period and `hcnt` as the high time;
    - start the divider if it is idle, otherwise discard the measurement;
    - reset `cnt`/`hcnt`; stay in MEASURE.
  - If `cnt` reaches 2^CNT_WIDTH−1 with no `rise`: go to STUCK.
- STUCK:
  - `stuck` = 1; `stuck_level` = sync.
  - `duty` forced to 0 (level low) or 2^WIDTH−1 (level high); `high_cnt`/`period_cnt` hold.
  - `valid` pulses once on entry.
  - On `rise`: `stuck` = 0, go to MEASURE. This edge only arms the next measurement and produces no result.

**Divider**
- Restoring shift-subtract: dividend = high·2^WIDTH, divisor = period.
- One quotient bit per cycle, WIDTH cycles; busy flag set while running.
- high < period always holds (a low phase is at least 1 cycle), so the quotient fits WIDTH bits with no saturation.
- On completion: register `duty`, `high_cnt`, `period_cnt`; pulse `valid`.

**Boundary conditions**
- Period ≤ WIDTH+1 cycles: the divider can still be busy, and new periods are silently dropped. Results are guaranteed only for period ≥ WIDTH+2.
- `rise` and timeout in the same cycle: `rise` wins.
- Glitches shorter than a clock may be missed; that is acceptable.
- `reset` asserted mid-measurement or mid-divide:
  - immediately returns to IDLE and aborts the divider;
  - all outputs go to reset values;
  - no `valid` pulse.

## Timing

- Reset values:
  - `duty` = 0, `high_cnt` = 0, `period_cnt` = 0;
  - `valid` = 0, `stuck` = 0, `stuck_level` = 0;
  - FSM in IDLE, divider idle.
- `pwm_in` rising edge captured at clock edge k: `rise` is high between edges k+1 and k+2, and the period latch/divider load happens at edge k+2.
- The divider iterates at edges k+3 … k+2+WIDTH. Outputs update, and `valid` is high, for the cycle after edge k+WIDTH+3. Latency from the closing edge is WIDTH+3 cycles.
- `stuck` asserts in the cycle after the counter reaches 2^CNT_WIDTH−1. It deasserts in the cycle after the edge where `rise` is seen.
- Outputs hold between `valid` pulses.
- The first valid result needs two rising edges after reset or after STUCK.

## Test plan

1. Period 256, high 128 (generator duty 128) → from the second period on, each `valid` gives `duty` = 128, `high_cnt` = 128, `period_cnt` = 256. `valid` comes WIDTH+3 = 11 cycles after each captured rising edge.
2. Duty sweep at period 256 with high 64, 192, 255 → `duty` = 64, 192, 255 respectively. No result mixes the old and new values across a change at a period boundary.
3. Period 1000, high 250 → `duty` = 64, `high_cnt` = 250, `period_cnt` = 1000.
4. Stuck detection:
   - hold `pwm_in` = 0 for 70000 cycles → `stuck` = 1, `stuck_level` = 0, `duty` = 0, one `valid` pulse;
   - repeat with `pwm_in` = 1 → `duty` = 255, `stuck_level` = 1;
   - restart a 256/128 waveform → `stuck` clears on the first `rise`, and `duty` = 128 after the following period.
5. Reset pulse mid-divide (5 cycles after the closing edge) → no `valid`, all outputs 0. With `pwm_in` held high across reset release, no measurement until a true low→high transition.
6. Period 6 (< WIDTH+2), high 3, continuously → no more than one result per WIDTH+1 cycles, and no corrupted `duty`: every reported value is 128.

Source files
------------

// File: rtl/pwm_capture.sv
// PWM capture: measures high time and period of an asynchronous PWM input in clk cycles
// and converts them to a normalised duty word with a WIDTH-cycle restoring divider.
module pwm_capture #(
    parameter int WIDTH     = 8,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 pwm_in,
    output logic [WIDTH-1:0]     duty,
    output logic [CNT_WIDTH-1:0] high_cnt,
    output logic [CNT_WIDTH-1:0] period_cnt,
    output logic                 valid,
    output logic                 stuck,
    output logic                 stuck_level
);

    localparam int STEP_W = $clog2(WIDTH + 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {IDLE, MEASURE, STUCK} state_t;

    state_t               state, next_state;
    logic                 sync_meta, sync, hist, rise;
    logic                 clr_cnt, latch_period, enter_stuck, start_div, div_done, div_ge;
    logic [CNT_WIDTH-1:0] cnt, hcnt;
    logic                 div_busy;
    logic [STEP_W-1:0]    div_step;
    logic [CNT_WIDTH-1:0] div_rem, div_period, div_high;
    logic [WIDTH-1:0]     div_quo;
    logic [CNT_WIDTH:0]   rem_shift, rem_sub;

    // Front end resets high so a line already high at reset release is not taken as an edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_meta <= 1'b1;
            sync      <= 1'b1;
            hist      <= 1'b1;
        end else begin
            sync_meta <= pwm_in;
            sync      <= sync_meta;
            hist      <= sync;
        end
    end

    assign rise = sync & ~hist;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        next_state   = state;
        clr_cnt      = 1'b0;
        latch_period = 1'b0;
        enter_stuck  = 1'b0;
        case (state)
            IDLE: begin
                if (rise) begin
                    clr_cnt    = 1'b1;
                    next_state = MEASURE;
                end
            end
            MEASURE: begin
                if (rise) begin
                    latch_period = 1'b1;
                    clr_cnt      = 1'b1;
                end else if (cnt == CNT_MAX) begin
                    enter_stuck = 1'b1;
                    next_state  = STUCK;
                end
            end
            STUCK: begin
                if (rise) begin
                    clr_cnt    = 1'b1;
                    next_state = MEASURE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // The rise cycle itself is high, so the high-time counter restarts at 1.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt  <= '0;
            hcnt <= '0;
        end else if (clr_cnt) begin
            cnt  <= '0;
            hcnt <= CNT_WIDTH'(1);
        end else if (state == MEASURE) begin
            cnt <= cnt + CNT_WIDTH'(1);
            if (sync) hcnt <= hcnt + CNT_WIDTH'(1);
        end else begin
            cnt  <= '0;
            hcnt <= '0;
        end
    end

    assign start_div = latch_period & ~div_busy;
    assign div_done  = div_busy && (div_step == STEP_W'(WIDTH));
    assign rem_shift = {div_rem, 1'b0};
    assign rem_sub   = rem_shift - {1'b0, div_period};
    assign div_ge    = rem_shift >= {1'b0, div_period};

    // high < period, so the remainder starts at high and only the low WIDTH quotient bits exist.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_busy   <= 1'b0;
            div_step   <= '0;
            div_rem    <= '0;
            div_period <= '0;
            div_high   <= '0;
            div_quo    <= '0;
        end else if (start_div) begin
            div_busy   <= 1'b1;
            div_step   <= '0;
            div_rem    <= hcnt;
            div_period <= cnt + CNT_WIDTH'(1);
            div_high   <= hcnt;
            div_quo    <= '0;
        end else if (div_done) begin
            div_busy <= 1'b0;
        end else if (div_busy) begin
            div_step <= div_step + STEP_W'(1);
            div_quo  <= {div_quo[WIDTH-2:0], div_ge};
            div_rem  <= div_ge ? rem_sub[CNT_WIDTH-1:0] : rem_shift[CNT_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            duty        <= '0;
            high_cnt    <= '0;
            period_cnt  <= '0;
            valid       <= 1'b0;
            stuck       <= 1'b0;
            stuck_level <= 1'b0;
        end else begin
            valid <= 1'b0;
            if (div_done) begin
                duty       <= div_quo;
                high_cnt   <= div_high;
                period_cnt <= div_period;
                valid      <= 1'b1;
            end
            if (enter_stuck) begin
                stuck       <= 1'b1;
                stuck_level <= sync;
                duty        <= {WIDTH{sync}};
                valid       <= 1'b1;
            end else if (state == STUCK) begin
                if (rise) begin
                    stuck <= 1'b0;
                end else begin
                    stuck_level <= sync;
                    duty        <= {WIDTH{sync}};
                end
            end
        end
    end

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture: duty/period measurement, stuck detection, reset abort
// and over-rate input, with a short counter width to keep the timeout runs brief.
module tb_pwm_capture;

    localparam int WIDTH     = 8;
    localparam int CNT_WIDTH = 12;
    localparam int TIMEOUT   = (1 << CNT_WIDTH) - 1;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 pwm_in;
    logic [WIDTH-1:0]     duty;
    logic [CNT_WIDTH-1:0] high_cnt;
    logic [CNT_WIDTH-1:0] period_cnt;
    logic                 valid;
    logic                 stuck;
    logic                 stuck_level;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_rise_cyc = 0;
    int valid_count = 0;
    int last_latency = 0;
    int prev_valid_cyc = 0;
    int min_gap = 1000;
    int t6_results = 0;
    bit t6_on = 1'b0;
    int v0;
    int sweep [3] = '{64, 192, 255};

    pwm_capture #(.WIDTH(WIDTH), .CNT_WIDTH(CNT_WIDTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .pwm_in     (pwm_in),
        .duty       (duty),
        .high_cnt   (high_cnt),
        .period_cnt (period_cnt),
        .valid      (valid),
        .stuck      (stuck),
        .stuck_level(stuck_level)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", name, observed, expected);
        end
    endtask

    // One PWM period: high for h cycles, low for p-h cycles, edges driven on negedge.
    task automatic drive_period(input int h, input int p);
        @(negedge clk);
        pwm_in = 1'b1;
        last_rise_cyc = cyc;
        repeat (h) @(negedge clk);
        pwm_in = 1'b0;
        repeat (p - h - 1) @(negedge clk);
    endtask

    task automatic hold(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Every reported result must equal floor(high*256/period) unless it is the stuck report.
    always @(negedge clk) begin
        if (valid) begin
            valid_count++;
            last_latency = cyc - last_rise_cyc;
            if (!stuck)
                check("div_model", duty, (int'(high_cnt) * 256) / int'(period_cnt));
            if (t6_on) begin
                t6_results++;
                if (t6_results > 1 && (cyc - prev_valid_cyc) < min_gap)
                    min_gap = cyc - prev_valid_cyc;
                check("t6_duty", duty, 128);
            end
            prev_valid_cyc = cyc;
        end
    end

    initial begin
        pwm_in = 1'b0;
        reset  = 1'b1;
        hold(3);
        check("rst_duty", duty, 0);
        check("rst_high", high_cnt, 0);
        check("rst_period", period_cnt, 0);
        check("rst_valid", valid, 0);
        check("rst_stuck", stuck, 0);
        check("rst_level", stuck_level, 0);
        reset = 1'b0;
        hold(5);

        // 256/128: first result only after the second rising edge
        repeat (3) drive_period(128, 256);
        check("t1_count", valid_count, 2);
        check("t1_duty", duty, 128);
        check("t1_high", high_cnt, 128);
        check("t1_period", period_cnt, 256);
        check("t1_latency", last_latency, WIDTH + 4);

        // duty sweep
        for (int i = 0; i < 3; i++) begin
            repeat (2) drive_period(sweep[i], 256);
            check("t2_duty", duty, sweep[i]);
            check("t2_high", high_cnt, sweep[i]);
            check("t2_period", period_cnt, 256);
        end

        repeat (2) drive_period(250, 1000);
        check("t3_duty", duty, 64);
        check("t3_high", high_cnt, 250);
        check("t3_period", period_cnt, 1000);

        // stuck low: counter hits max 4098 cycles after the driven rise, stuck one cycle later
        v0 = valid_count;
        while (cyc < last_rise_cyc + TIMEOUT + 3) @(negedge clk);
        check("t4_not_yet", stuck, 0);
        @(negedge clk);
        check("t4_stuck", stuck, 1);
        check("t4_valid_pulse", valid, 1);
        @(negedge clk);
        check("t4_valid_low", valid, 0);
        hold(20);
        check("t4_level", stuck_level, 0);
        check("t4_duty", duty, 0);
        check("t4_one_valid", valid_count - v0, 1);
        check("t4_high_hold", high_cnt, 250);
        check("t4_period_hold", period_cnt, 1000);

        // stuck high: the rise clears stuck, then the line stays high until timeout
        @(negedge clk);
        pwm_in = 1'b1;
        last_rise_cyc = cyc;
        v0 = valid_count;
        hold(2);
        check("t4h_still_stuck", stuck, 1);
        hold(1);
        check("t4h_cleared", stuck, 0);
        while (cyc < last_rise_cyc + TIMEOUT + 3) @(negedge clk);
        check("t4h_not_yet", stuck, 0);
        @(negedge clk);
        check("t4h_stuck", stuck, 1);
        check("t4h_level", stuck_level, 1);
        check("t4h_duty", duty, 255);
        hold(5);
        check("t4h_one_valid", valid_count - v0, 1);
        check("t4h_period_hold", period_cnt, 1000);

        // restart: first rise only re-arms
        pwm_in = 1'b0;
        hold(10);
        v0 = valid_count;
        drive_period(128, 256);
        check("t4r_stuck_clr", stuck, 0);
        check("t4r_no_result", valid_count, v0);
        drive_period(128, 256);
        check("t4r_result", valid_count, v0 + 1);
        check("t4r_duty", duty, 128);

        // reset five cycles into a divide, input held high across release
        @(negedge clk);
        pwm_in = 1'b1;
        last_rise_cyc = cyc;
        v0 = valid_count;
        hold(5);
        reset = 1'b1;
        @(negedge clk);
        check("t5_duty", duty, 0);
        check("t5_high", high_cnt, 0);
        check("t5_period", period_cnt, 0);
        check("t5_valid", valid, 0);
        hold(2);
        reset = 1'b0;
        hold(30);
        check("t5_no_valid", valid_count, v0);
        check("t5_duty_held", duty, 0);
        pwm_in = 1'b0;
        hold(20);
        drive_period(128, 256);
        check("t5_armed_only", valid_count, v0);
        drive_period(128, 256);
        check("t5_result", valid_count, v0 + 1);
        check("t5_res_duty", duty, 128);

        // period 6: every other period is dropped while the divider is busy
        t6_on = 1'b1;
        repeat (40) drive_period(3, 6);
        hold(20);
        t6_on = 1'b0;
        check("t6_results", t6_results, 20);
        check("t6_min_gap_ok", min_gap >= WIDTH + 1, 1);
        check("t6_high", high_cnt, 3);
        check("t6_period", period_cnt, 6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
